tcp_tx_client: RTL and testbench
================================

# tcp_tx_client

Application-side TCP transmitter that drives the network stack's TCP application interface from the user side. On a start pulse it opens one connection to a configured remote IP/port, sends a configured number of fixed-length packets with a deterministic payload, honours the stack's per-packet tx status (retrying refused packets), closes the session and reports counters. It sits beside the network stack in the kernel and is the producer for the stack's tx metadata/tx data ports, and the consumer for its open status and tx status ports.

## Interface
- DATA_WIDTH, 512: tx data stream width in bits; keep width is DATA_WIDTH/8.
- MAX_RETRY, 1023: refused-packet retries per packet before abort.

- aclk  in  1  sole clock.
- sys_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- remote_ip  in  32  destination IPv4 address, latched on start.
- remote_port  in  16  destination port, latched on start.
- pkt_len  in  16  bytes per packet, 1..65535, latched on start.
- num_pkts  in  32  packets to send, latched on start; 0 means open then close.
- m_open_conn_valid/ready/data  out/in/out  1/1/48  data = {remote_port, remote_ip}.
- s_open_status_valid/ready/data  in/out/in  1/1/24  [15:0] session, [16] success.
- m_tx_meta_valid/ready/data  out/in/out  1/1/32  data = {pkt_len, session}.
- s_tx_status_valid/ready/data  in/out/in  1/1/64  [15:0] session, [31:16] length, [60:32] space, [63:61] error.
- m_tx_data_valid/ready/data/keep/last  out/in/out/out/out  1/1/DATA_WIDTH/64/1  payload.
- m_close_conn_valid/ready/data  out/in/out  1/1/16  session to close.
- busy  out  1  high outside IDLE/DONE.
- done  out  1  one-cycle pulse on entry to DONE.
- open_failed  out  1  sticky until next start.
- aborted  out  1  sticky until next start; retry limit hit.
- pkts_sent  out  32  packets whose tx status returned error 0.
- retries  out  32  total refused tx status responses.
- tx_cycles  out  64  cycles from first meta handshake to close handshake.

## Operation
- States: IDLE, OPEN, WAIT_OPEN, META, WAIT_STS, DATA, CLOSE, DONE.
- IDLE: start -> latch config, clear counters/flags, go OPEN.
- OPEN: assert m_open_conn_valid; on handshake -> WAIT_OPEN.
- WAIT_OPEN: s_open_status_ready=1. success=1 -> latch session; num_pkts=0 ? CLOSE : META. success=0 -> set open_failed, DONE (no close).
- META: assert m_tx_meta_valid; on handshake -> WAIT_STS; first handshake of the run starts tx_cycles.
- WAIT_STS: s_tx_status_ready=1. error==0 -> DATA. error!=0 -> retries++, per-packet retry count++; count==MAX_RETRY -> set aborted, CLOSE; else META.
- DATA: beats = ceil(pkt_len/64); beat word = 16 copies of 32-bit global word counter (starts 0 per run, increments per accepted beat). keep all ones except last beat: low (pkt_len mod 64) bits set, all ones if mod 0. last on final beat. After last handshake: pkts_sent++; pkts_sent==num_pkts -> CLOSE else META.
- CLOSE: assert m_close_conn_valid with session; on handshake stop tx_cycles -> DONE.
- DONE: done pulse, then IDLE next cycle. Counters hold until next start.
- Counters saturate, never wrap; tx_cycles is 64-bit and increments every cycle while active.

## Timing
- Reset: state IDLE; all valid/ready outputs 0; data/keep/last 0; busy, done, open_failed, aborted 0; all counters 0.
- All valid outputs registered, held stable with data until ready; no deassertion without handshake.
- Ready outputs are combinational from state only; never depend on input valid.
- start -> m_open_conn_valid: 1 cycle. Each handshake -> next state's valid: 1 cycle (one idle cycle between phases acceptable, no more).
- DATA: one beat per cycle while ready=1; no bubbles.
- start while busy: ignored. sys_reset mid-operation: immediate return to reset values; no close issued.
- Status session mismatch: treated as error != 0 (counted as retry).

## Test plan
- pkt_len=128, num_pkts=3, all ready=1, statuses ok -> 3 metas {128,sess}, 6 beats, words 0..5, keep all ones, last on beats 2,4,6; pkts_sent=3, retries=0, one close, done pulse.
- pkt_len=100 -> 2 beats, second keep=0x0000000000000000_FFFFFFFFF (36 ones, 64'h0000000FFFFFFFFF), last=1.
- open status success=0 -> open_failed=1, no meta/close, done pulse, busy=0.
- first tx status error=3'b001, then ok -> meta issued twice, retries=1, pkts_sent=1, data only after ok.
- random ready deassertion on all masters -> payload/meta sequence identical to full-throughput run, valid never drops pre-handshake.
- sys_reset mid-DATA -> next cycle all outputs at reset values; subsequent start runs cleanly from word 0.

Source files
------------

// File: rtl/tcp_tx_client.sv
// Application-side TCP transmitter: opens one session, streams num_pkts fixed-length
// packets with a word-counter payload, retries refused packets, closes and reports.
module tcp_tx_client #(
    parameter int DATA_WIDTH = 512,
    parameter int MAX_RETRY  = 1023
) (
    input  logic                    aclk,
    input  logic                    sys_reset,
    input  logic                    start,
    input  logic [31:0]             remote_ip,
    input  logic [15:0]             remote_port,
    input  logic [15:0]             pkt_len,
    input  logic [31:0]             num_pkts,
    output logic                    m_open_conn_valid,
    input  logic                    m_open_conn_ready,
    output logic [47:0]             m_open_conn_data,
    input  logic                    s_open_status_valid,
    output logic                    s_open_status_ready,
    input  logic [23:0]             s_open_status_data,
    output logic                    m_tx_meta_valid,
    input  logic                    m_tx_meta_ready,
    output logic [31:0]             m_tx_meta_data,
    input  logic                    s_tx_status_valid,
    output logic                    s_tx_status_ready,
    input  logic [63:0]             s_tx_status_data,
    output logic                    m_tx_data_valid,
    input  logic                    m_tx_data_ready,
    output logic [DATA_WIDTH-1:0]   m_tx_data_data,
    output logic [DATA_WIDTH/8-1:0] m_tx_data_keep,
    output logic                    m_tx_data_last,
    output logic                    m_close_conn_valid,
    input  logic                    m_close_conn_ready,
    output logic [15:0]             m_close_conn_data,
    output logic                    busy,
    output logic                    done,
    output logic                    open_failed,
    output logic                    aborted,
    output logic [31:0]             pkts_sent,
    output logic [31:0]             retries,
    output logic [63:0]             tx_cycles
);
    localparam int KW    = DATA_WIDTH / 8;
    localparam int KB    = $clog2(KW);
    localparam int NWORD = DATA_WIDTH / 32;

    typedef enum logic [2:0] {
        S_IDLE, S_OPEN, S_WAIT_OPEN, S_META, S_WAIT_STS, S_DATA, S_CLOSE, S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [31:0]           r_ip, r_num, r_word, r_pkt_retry;
    logic [15:0]           r_port, r_len, r_session;
    logic                  r_open_valid, r_meta_valid, r_data_valid, r_close_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [KW-1:0]         r_keep;
    logic                  r_last, r_done, r_open_failed, r_aborted, r_tx_active;
    logic [31:0]           r_pkts_sent, r_retries;
    logic [63:0]           r_tx_cycles;
    logic [16:0]           r_beats_left;

    logic                  w_open_hs, w_meta_hs, w_beat_hs, w_last_hs, w_close_hs;
    logic                  w_sts_hs, w_sts_bad, w_retry_limit, w_last_pkt, w_open_ok;
    logic [16:0]           w_beats_total;
    logic [KB-1:0]         w_rem;
    logic [KW-1:0]         w_last_keep;
    logic [31:0]           w_word_next;
    logic                  w_unused_bits;

    assign w_open_hs     = r_open_valid & m_open_conn_ready;
    assign w_meta_hs     = r_meta_valid & m_tx_meta_ready;
    assign w_beat_hs     = r_data_valid & m_tx_data_ready;
    assign w_last_hs     = w_beat_hs & r_last;
    assign w_close_hs    = r_close_valid & m_close_conn_ready;
    assign w_sts_hs      = (r_state == S_WAIT_STS) & s_tx_status_valid;
    assign w_open_ok     = s_open_status_data[16];
    // A status for a foreign session is treated exactly like a refusal.
    assign w_sts_bad     = (s_tx_status_data[63:61] != 3'd0) ||
                           (s_tx_status_data[15:0] != r_session);
    assign w_retry_limit = (r_pkt_retry >= 32'(MAX_RETRY - 1));
    assign w_last_pkt    = ((r_pkts_sent + 32'd1) == r_num);
    assign w_beats_total = 17'((18'(r_len) + 18'(KW - 1)) >> KB);
    assign w_rem         = r_len[KB-1:0];
    assign w_last_keep   = (w_rem == '0) ? '1 : ~({KW{1'b1}} << w_rem);
    assign w_word_next   = r_word + 32'd1;
    assign w_unused_bits = ^{s_open_status_data[23:17], s_tx_status_data[60:16]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next = S_OPEN;
            S_OPEN:      if (w_open_hs) w_next = S_WAIT_OPEN;
            S_WAIT_OPEN: if (s_open_status_valid)
                             w_next = !w_open_ok ? S_DONE : (r_num == 32'd0) ? S_CLOSE : S_META;
            S_META:      if (w_meta_hs) w_next = S_WAIT_STS;
            S_WAIT_STS:  if (s_tx_status_valid)
                             w_next = !w_sts_bad ? S_DATA : w_retry_limit ? S_CLOSE : S_META;
            S_DATA:      if (w_last_hs) w_next = w_last_pkt ? S_CLOSE : S_META;
            S_CLOSE:     if (w_close_hs) w_next = S_DONE;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (sys_reset) begin
            r_state       <= S_IDLE;
            r_ip          <= '0;
            r_port        <= '0;
            r_len         <= '0;
            r_num         <= '0;
            r_session     <= '0;
            r_open_valid  <= 1'b0;
            r_meta_valid  <= 1'b0;
            r_data_valid  <= 1'b0;
            r_close_valid <= 1'b0;
            r_data        <= '0;
            r_keep        <= '0;
            r_last        <= 1'b0;
            r_done        <= 1'b0;
            r_open_failed <= 1'b0;
            r_aborted     <= 1'b0;
            r_tx_active   <= 1'b0;
            r_pkts_sent   <= '0;
            r_retries     <= '0;
            r_tx_cycles   <= '0;
            r_word        <= '0;
            r_pkt_retry   <= '0;
            r_beats_left  <= '0;
        end else begin
            r_state       <= w_next;
            // Valids are registered from the next state so they hold until handshake.
            r_open_valid  <= (w_next == S_OPEN);
            r_meta_valid  <= (w_next == S_META);
            r_data_valid  <= (w_next == S_DATA);
            r_close_valid <= (w_next == S_CLOSE);
            r_done        <= (w_next == S_DONE) && (r_state != S_DONE);

            if (r_tx_active && r_tx_cycles != '1)
                r_tx_cycles <= r_tx_cycles + 64'd1;

            if (r_state == S_IDLE && start) begin
                r_ip          <= remote_ip;
                r_port        <= remote_port;
                r_len         <= pkt_len;
                r_num         <= num_pkts;
                r_open_failed <= 1'b0;
                r_aborted     <= 1'b0;
                r_pkts_sent   <= '0;
                r_retries     <= '0;
                r_tx_cycles   <= '0;
                r_tx_active   <= 1'b0;
                r_word        <= '0;
                r_pkt_retry   <= '0;
            end

            if (r_state == S_WAIT_OPEN && s_open_status_valid) begin
                if (w_open_ok) r_session <= s_open_status_data[15:0];
                else           r_open_failed <= 1'b1;
            end

            if (w_meta_hs) r_tx_active <= 1'b1;

            if (w_sts_hs) begin
                if (w_sts_bad) begin
                    if (r_retries != '1) r_retries <= r_retries + 32'd1;
                    r_pkt_retry <= r_pkt_retry + 32'd1;
                    if (w_retry_limit) r_aborted <= 1'b1;
                end else begin
                    r_pkt_retry  <= '0;
                    r_beats_left <= w_beats_total;
                    r_data       <= {NWORD{r_word}};
                    r_last       <= (w_beats_total == 17'd1);
                    r_keep       <= (w_beats_total == 17'd1) ? w_last_keep : '1;
                end
            end

            if (w_beat_hs) begin
                r_word <= w_word_next;
                if (r_last) begin
                    if (r_pkts_sent != '1) r_pkts_sent <= r_pkts_sent + 32'd1;
                end else begin
                    r_beats_left <= r_beats_left - 17'd1;
                    r_data       <= {NWORD{w_word_next}};
                    r_last       <= (r_beats_left == 17'd2);
                    r_keep       <= (r_beats_left == 17'd2) ? w_last_keep : '1;
                end
            end

            if (w_close_hs) r_tx_active <= 1'b0;
        end
    end

    assign m_open_conn_valid   = r_open_valid;
    assign m_open_conn_data    = {r_port, r_ip};
    assign s_open_status_ready = (r_state == S_WAIT_OPEN);
    assign m_tx_meta_valid     = r_meta_valid;
    assign m_tx_meta_data      = {r_len, r_session};
    assign s_tx_status_ready   = (r_state == S_WAIT_STS);
    assign m_tx_data_valid     = r_data_valid;
    assign m_tx_data_data      = r_data;
    assign m_tx_data_keep      = r_keep;
    assign m_tx_data_last      = r_last;
    assign m_close_conn_valid  = r_close_valid;
    assign m_close_conn_data   = r_session;
    assign busy                = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done                = r_done;
    assign open_failed         = r_open_failed;
    assign aborted             = r_aborted;
    assign pkts_sent           = r_pkts_sent;
    assign retries             = r_retries;
    assign tx_cycles           = r_tx_cycles;
endmodule

// File: tb/tb_tcp_tx_client.sv
// Directed self-checking bench for tcp_tx_client with a small stack responder.
module tb_tcp_tx_client;
    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam logic [15:0] SESS = 16'h0A5C;

    logic aclk = 1'b0, sys_reset = 1'b1, start = 1'b0;
    logic [31:0] remote_ip = 32'hC0A8_0102;
    logic [15:0] remote_port = 16'd5001, pkt_len = 16'd0;
    logic [31:0] num_pkts = 32'd0;
    logic m_open_conn_valid, m_open_conn_ready, s_open_status_valid, s_open_status_ready;
    logic [47:0] m_open_conn_data;
    logic [23:0] s_open_status_data;
    logic m_tx_meta_valid, m_tx_meta_ready, s_tx_status_valid, s_tx_status_ready;
    logic [31:0] m_tx_meta_data;
    logic [63:0] s_tx_status_data;
    logic m_tx_data_valid, m_tx_data_ready, m_tx_data_last;
    logic [DW-1:0] m_tx_data_data;
    logic [KW-1:0] m_tx_data_keep;
    logic m_close_conn_valid, m_close_conn_ready;
    logic [15:0] m_close_conn_data;
    logic busy, done, open_failed, aborted;
    logic [31:0] pkts_sent, retries;
    logic [63:0] tx_cycles;

    tcp_tx_client #(.DATA_WIDTH(DW), .MAX_RETRY(3)) dut (
        .aclk(aclk), .sys_reset(sys_reset), .start(start),
        .remote_ip(remote_ip), .remote_port(remote_port), .pkt_len(pkt_len), .num_pkts(num_pkts),
        .m_open_conn_valid(m_open_conn_valid), .m_open_conn_ready(m_open_conn_ready),
        .m_open_conn_data(m_open_conn_data),
        .s_open_status_valid(s_open_status_valid), .s_open_status_ready(s_open_status_ready),
        .s_open_status_data(s_open_status_data),
        .m_tx_meta_valid(m_tx_meta_valid), .m_tx_meta_ready(m_tx_meta_ready),
        .m_tx_meta_data(m_tx_meta_data),
        .s_tx_status_valid(s_tx_status_valid), .s_tx_status_ready(s_tx_status_ready),
        .s_tx_status_data(s_tx_status_data),
        .m_tx_data_valid(m_tx_data_valid), .m_tx_data_ready(m_tx_data_ready),
        .m_tx_data_data(m_tx_data_data), .m_tx_data_keep(m_tx_data_keep),
        .m_tx_data_last(m_tx_data_last),
        .m_close_conn_valid(m_close_conn_valid), .m_close_conn_ready(m_close_conn_ready),
        .m_close_conn_data(m_close_conn_data),
        .busy(busy), .done(done), .open_failed(open_failed), .aborted(aborted),
        .pkts_sent(pkts_sent), .retries(retries), .tx_cycles(tx_cycles)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input logic [31:0] w);
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = w;
        return r;
    endfunction

    // Responder configuration and captured traffic
    logic open_ok = 1'b1, rnd_mode = 1'b0;
    logic [2:0] sts_err [0:7];
    logic       sts_bad [0:7];
    int sts_idx = 0, open_cnt = 0, meta_cnt = 0, beat_cnt = 0, close_cnt = 0, done_cnt = 0, viol = 0;
    logic [47:0]   open_d;
    logic [31:0]   meta_d [0:15];
    logic [DW-1:0] beat_d [0:31];
    logic [KW-1:0] beat_k [0:31];
    logic          beat_l [0:31];
    logic [15:0]   close_d;
    logic pm_v = 0, pm_r = 0, pd_v = 0, pd_r = 0, pc_v = 0, pc_r = 0;
    logic [31:0]   pm_d;
    logic [DW-1:0] pd_d;

    assign s_open_status_valid = 1'b1;
    assign s_tx_status_valid   = 1'b1;
    assign s_open_status_data  = {7'd0, open_ok, SESS};

    always @(posedge aclk) begin
        #1;
        m_open_conn_ready  = rnd_mode ? 1'($urandom % 2) : 1'b1;
        m_tx_meta_ready    = rnd_mode ? 1'($urandom % 2) : 1'b1;
        m_tx_data_ready    = rnd_mode ? 1'($urandom % 2) : 1'b1;
        m_close_conn_ready = rnd_mode ? 1'($urandom % 2) : 1'b1;
        if (sts_idx < 8)
            s_tx_status_data = {sts_err[sts_idx], 29'd4096, pkt_len, sts_bad[sts_idx] ? 16'h1111 : SESS};
        else
            s_tx_status_data = {3'd0, 29'd4096, pkt_len, SESS};
    end

    always @(negedge aclk) begin
        if (sys_reset) begin
            pm_v = 0; pd_v = 0; pc_v = 0;
        end else begin
            if (pm_v && !pm_r && (!m_tx_meta_valid || m_tx_meta_data != pm_d)) viol++;
            if (pd_v && !pd_r && (!m_tx_data_valid || m_tx_data_data != pd_d)) viol++;
            if (pc_v && !pc_r && !m_close_conn_valid) viol++;
            pm_v = m_tx_meta_valid;  pm_r = m_tx_meta_ready;  pm_d = m_tx_meta_data;
            pd_v = m_tx_data_valid;  pd_r = m_tx_data_ready;  pd_d = m_tx_data_data;
            pc_v = m_close_conn_valid; pc_r = m_close_conn_ready;
            if (m_open_conn_valid && m_open_conn_ready) begin open_d = m_open_conn_data; open_cnt++; end
            if (m_tx_meta_valid && m_tx_meta_ready) begin
                if (meta_cnt < 16) meta_d[meta_cnt] = m_tx_meta_data;
                meta_cnt++;
            end
            if (s_tx_status_valid && s_tx_status_ready) sts_idx++;
            if (m_tx_data_valid && m_tx_data_ready) begin
                if (beat_cnt < 32) begin
                    beat_d[beat_cnt] = m_tx_data_data;
                    beat_k[beat_cnt] = m_tx_data_keep;
                    beat_l[beat_cnt] = m_tx_data_last;
                end
                beat_cnt++;
            end
            if (m_close_conn_valid && m_close_conn_ready) begin close_d = m_close_conn_data; close_cnt++; end
            if (done) done_cnt++;
        end
    end

    task automatic clear_sts();
        for (int i = 0; i < 8; i++) begin sts_err[i] = 3'd0; sts_bad[i] = 1'b0; end
    endtask

    task automatic launch(input logic [15:0] len, input logic [31:0] n, input logic ok, input logic rnd);
        open_cnt = 0; meta_cnt = 0; beat_cnt = 0; close_cnt = 0; done_cnt = 0; viol = 0; sts_idx = 0;
        open_ok = ok; rnd_mode = rnd;
        @(posedge aclk); #2;
        pkt_len = len; num_pkts = n; start = 1'b1;
        @(posedge aclk); #2;
        start = 1'b0;
    endtask

    task automatic run_pkt(input logic [15:0] len, input logic [31:0] n, input logic ok, input logic rnd);
        launch(len, n, ok, rnd);
        for (int c = 0; c < 4000; c++) begin
            @(posedge aclk);
            if (done_cnt != 0) break;
        end
        repeat (3) @(negedge aclk);
        check("done_pulses", done_cnt, 1);
        check("busy_after", busy, 0);
        check("stable_valids", viol, 0);
    endtask

    task automatic check_full_run(input string t);
        check({t, "_metas"}, meta_cnt, 3);
        for (int i = 0; i < 3; i++) check({t, "_meta_data"}, meta_d[i], {16'd128, SESS});
        check({t, "_beats"}, beat_cnt, 6);
        for (int i = 0; i < 6; i++) begin
            check({t, "_word"}, beat_d[i], rep(32'(i)));
            check({t, "_keep"}, beat_k[i], {KW{1'b1}});
            check({t, "_last"}, beat_l[i], (i % 2) == 1);
        end
        check({t, "_pkts_sent"}, pkts_sent, 3);
        check({t, "_retries"}, retries, 0);
        check({t, "_closes"}, close_cnt, 1);
        check({t, "_close_data"}, close_d, SESS);
    endtask

    initial begin
        clear_sts();
        m_open_conn_ready = 1; m_tx_meta_ready = 1; m_tx_data_ready = 1; m_close_conn_ready = 1;
        s_tx_status_data = '0;
        repeat (3) @(posedge aclk);
        #2 sys_reset = 1'b0;
        @(negedge aclk);
        check("reset_flags", {m_open_conn_valid, m_tx_meta_valid, m_tx_data_valid, m_tx_data_last,
                              m_close_conn_valid, busy, done, open_failed, aborted,
                              s_open_status_ready, s_tx_status_ready}, 0);
        check("reset_counters", {pkts_sent, retries, tx_cycles}, 0);
        check("reset_data", {m_tx_data_data, m_tx_data_keep}, 0);

        // Full-throughput baseline: 3 x 128 bytes
        run_pkt(16'd128, 32'd3, 1'b1, 1'b0);
        check("t1_open_data", open_d, {16'd5001, 32'hC0A8_0102});
        check_full_run("t1");
        check("t1_tx_cycles", tx_cycles, 12);

        // Partial last beat: 100 bytes -> 64 + 36
        run_pkt(16'd100, 32'd1, 1'b1, 1'b0);
        check("t2_beats", beat_cnt, 2);
        check("t2_keep0", beat_k[0], {KW{1'b1}});
        check("t2_keep1", beat_k[1], 64'h0000000FFFFFFFFF);
        check("t2_last", {beat_l[0], beat_l[1]}, 2'b01);

        // Open refused
        run_pkt(16'd128, 32'd3, 1'b0, 1'b0);
        check("t3_open_failed", open_failed, 1);
        check("t3_metas", meta_cnt, 0);
        check("t3_closes", close_cnt, 0);

        // One refusal then accept
        sts_err[0] = 3'b001;
        run_pkt(16'd64, 32'd1, 1'b1, 1'b0);
        check("t4_metas", meta_cnt, 2);
        check("t4_retries", retries, 1);
        check("t4_pkts_sent", pkts_sent, 1);
        check("t4_beats", beat_cnt, 1);
        check("t4_keep", beat_k[0], {KW{1'b1}});
        check("t4_word", beat_d[0], rep(32'd0));
        clear_sts();

        // Session mismatch counts as a refusal
        sts_bad[0] = 1'b1;
        run_pkt(16'd64, 32'd1, 1'b1, 1'b0);
        check("t4b_metas", meta_cnt, 2);
        check("t4b_retries", retries, 1);
        clear_sts();

        // Retry limit (MAX_RETRY=3) aborts and closes
        for (int i = 0; i < 8; i++) sts_err[i] = 3'b010;
        run_pkt(16'd64, 32'd2, 1'b1, 1'b0);
        check("t5_aborted", aborted, 1);
        check("t5_retries", retries, 3);
        check("t5_metas", meta_cnt, 3);
        check("t5_beats", beat_cnt, 0);
        check("t5_closes", close_cnt, 1);
        check("t5_pkts_sent", pkts_sent, 0);
        clear_sts();

        // Zero packets: open then close
        run_pkt(16'd64, 32'd0, 1'b1, 1'b0);
        check("t6_metas", meta_cnt, 0);
        check("t6_closes", close_cnt, 1);
        check("t6_tx_cycles", tx_cycles, 0);
        check("t6_flags", {open_failed, aborted}, 0);

        // Random backpressure must not change the traffic
        run_pkt(16'd128, 32'd3, 1'b1, 1'b1);
        check_full_run("t7");
        rnd_mode = 1'b0;

        // Reset during DATA
        launch(16'd640, 32'd2, 1'b1, 1'b0);
        for (int c = 0; c < 200; c++) begin
            @(posedge aclk);
            if (beat_cnt >= 3) break;
        end
        check("t8_reached_data", beat_cnt >= 3, 1);
        #2 sys_reset = 1'b1;
        @(posedge aclk); #2 sys_reset = 1'b0;
        @(negedge aclk);
        check("t8_rst_flags", {m_open_conn_valid, m_tx_meta_valid, m_tx_data_valid, m_tx_data_last,
                               m_close_conn_valid, busy, done, s_tx_status_ready}, 0);
        check("t8_rst_data", {m_tx_data_data, m_tx_data_keep}, 0);
        check("t8_rst_counters", {pkts_sent, retries, tx_cycles}, 0);
        repeat (5) @(negedge aclk);
        check("t8_no_close", close_cnt, 0);
        run_pkt(16'd128, 32'd3, 1'b1, 1'b0);
        check_full_run("t8");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
